cavlc_bit_window: RTL and testbench

- Bit-aligned bitstream front end for the CAVLC decoder.
- Accepts 32-bit big-endian slice-data words from the word fetcher and presents a left-aligned window of the next unconsumed bits to the coeff_token, level and run decoders. Those decoders include the CoeffTokenLUT family, which take Bits slices of the window.
- Consumes a per-cycle shift count (the LUTs' NumShift) to advance the bit pointer.
- Sits directly upstream of the coeff_token lookup stage and closes its shift feedback loop.

---
 rtl/cavlc_pkg.sv | 12 +
 rtl/cavlc_bit_window_if.sv | 27 ++
 rtl/cavlc_barrel_shl.sv | 21 ++
 rtl/cavlc_bit_window.sv | 98 +++++++++
 tb/tb_cavlc_bit_window.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cavlc_pkg.sv
// Shared constants for the CAVLC bitstream front end.
package cavlc_pkg;

    localparam int IN_W    = 32;
    localparam int BUF_W   = 64;
    localparam int WIN_W   = 32;
    localparam int SHIFT_W = 5;

    // Fill must be able to represent BUF_W itself, hence the +1.
    localparam int FILL_W  = $clog2(BUF_W + 1);

endpackage

// File: rtl/cavlc_bit_window_if.sv
// Word-in / window-out bundle between the fetcher, bit window and symbol decoders.
interface cavlc_bit_window_if
    import cavlc_pkg::*;
();

    logic [IN_W-1:0]    InData;
    logic               InValid;
    logic               InReady;
    logic [WIN_W-1:0]   Window;
    logic               WindowValid;
    logic               Shift;
    logic [SHIFT_W-1:0] ShiftAmt;
    logic               Flush;
    logic [31:0]        BitsConsumed;
    logic               Underflow;

    modport master (
        output InData, InValid, Shift, ShiftAmt, Flush,
        input  InReady, Window, WindowValid, BitsConsumed, Underflow
    );

    modport slave (
        input  InData, InValid, Shift, ShiftAmt, Flush,
        output InReady, Window, WindowValid, BitsConsumed, Underflow
    );

endinterface

// File: rtl/cavlc_barrel_shl.sv
// Combinational BUF_W-bit logarithmic left shifter, zero fill, shift 0..2^SHIFT_W-1.
module cavlc_barrel_shl
    import cavlc_pkg::*;
(
    input  logic [BUF_W-1:0]   i_data,
    input  logic [SHIFT_W-1:0] i_amt,
    output logic [BUF_W-1:0]   o_data
);

    logic [BUF_W-1:0] w_stage [SHIFT_W+1];

    assign w_stage[0] = i_data;

    // Stage k shifts by 2^k when bit k of the amount is set.
    for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
        assign w_stage[k+1] = i_amt[k] ? (w_stage[k] << (2 ** k)) : w_stage[k];
    end

    assign o_data = w_stage[SHIFT_W];

endmodule

// File: rtl/cavlc_bit_window.sv
// Left-aligned bit window over a 32-bit word stream; consumes NumShift bits per cycle.
module cavlc_bit_window
    import cavlc_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    cavlc_bit_window_if.slave bw
);

    localparam logic [FILL_W-1:0] FILL_WIN  = FILL_W'(WIN_W);
    localparam logic [FILL_W-1:0] FILL_IN   = FILL_W'(IN_W);
    localparam logic [FILL_W-1:0] FILL_ROOM = FILL_W'(BUF_W - IN_W);

    logic [BUF_W-1:0]  r_buf;
    logic [FILL_W-1:0] r_fill;
    logic [31:0]       r_bits_consumed;
    logic              r_underflow;

    logic              w_window_valid;
    logic              w_room;
    logic              w_shift_req;
    logic              w_do_shift;
    logic              w_do_load;
    logic [FILL_W-1:0] w_shift_amt;
    logic [BUF_W-1:0]  w_shifted;
    logic [BUF_W-1:0]  w_post_buf;
    logic [FILL_W-1:0] w_post_fill;
    logic [BUF_W-1:0]  w_word_aligned;
    logic [BUF_W-1:0]  w_next_buf;
    logic [FILL_W-1:0] w_next_fill;

    assign w_window_valid = (r_fill >= FILL_WIN);
    // Ready looks only at registered fill so the decoder's Shift never loops back into it.
    assign w_room         = (r_fill <= FILL_ROOM);
    assign w_shift_amt    = FILL_W'(bw.ShiftAmt);
    assign w_shift_req    = bw.Shift && (bw.ShiftAmt != '0);
    assign w_do_shift     = w_shift_req && w_window_valid && !bw.Flush;
    assign w_do_load      = bw.InValid && w_room && !bw.Flush;

    cavlc_barrel_shl u_shl (
        .i_data (r_buf),
        .i_amt  (bw.ShiftAmt),
        .o_data (w_shifted)
    );

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        w_post_buf  = r_buf;
        w_post_fill = r_fill;
        w_next_buf  = r_buf;
        w_next_fill = r_fill;

        if (w_do_shift) begin
            w_post_buf  = w_shifted;
            w_post_fill = r_fill - w_shift_amt;
        end

        // The new word lands right after the last valid bit left by this cycle's shift.
        w_word_aligned = {bw.InData, {(BUF_W-IN_W){1'b0}}} >> w_post_fill;

        w_next_buf  = w_post_buf;
        w_next_fill = w_post_fill;
        if (w_do_load) begin
            w_next_buf  = w_post_buf | w_word_aligned;
            w_next_fill = w_post_fill + FILL_IN;
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (Rst) begin
            r_buf           <= '0;
            r_fill          <= '0;
            r_bits_consumed <= '0;
            r_underflow     <= 1'b0;
        end else if (bw.Flush) begin
            r_buf       <= '0;
            r_fill      <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_buf  <= w_next_buf;
            r_fill <= w_next_fill;
            if (w_do_shift) begin
                r_bits_consumed <= r_bits_consumed + 32'(bw.ShiftAmt);
            end
            if (w_shift_req && !w_window_valid) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bw.InReady      = !Rst && w_room;
    assign bw.Window       = Rst ? '0 : r_buf[BUF_W-1 -: WIN_W];
    assign bw.WindowValid  = !Rst && w_window_valid;
    assign bw.BitsConsumed = r_bits_consumed;
    assign bw.Underflow    = r_underflow;

endmodule

// File: tb/tb_cavlc_bit_window.sv
// Self-checking bench for cavlc_bit_window against a bit-queue reference model.
module tb_cavlc_bit_window;
    import cavlc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cavlc_bit_window_if bw_if ();

    cavlc_bit_window dut (
        .Clk (clk),
        .Rst (rst),
        .bw  (bw_if.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: the buffered bitstream as a plain queue of bits, earliest first.
    bit          model_q[$];
    int unsigned model_consumed;
    bit          model_underflow;

    function automatic logic [31:0] model_window();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < model_q.size()) w[31-i] = model_q[i];
        end
        return w;
    endfunction

    function automatic void model_step(logic valid, logic [31:0] data, logic sh,
                                       logic [4:0] amt, logic fl);
        bit room;
        room = (model_q.size() <= 32);
        if (fl) begin
            model_q.delete();
            model_underflow = 1'b0;
            return;
        end
        if (sh && amt != 0) begin
            if (model_q.size() >= 32) begin
                for (int i = 0; i < int'(amt); i++) void'(model_q.pop_front());
                model_consumed += amt;
            end else begin
                model_underflow = 1'b1;
            end
        end
        if (valid && room) begin
            for (int i = 31; i >= 0; i--) model_q.push_back(data[i]);
        end
    endfunction

    task automatic drive(input logic valid, input logic [31:0] data, input logic sh,
                         input logic [4:0] amt, input logic fl);
        @(negedge clk);
        bw_if.InValid  = valid;
        bw_if.InData   = data;
        bw_if.Shift    = sh;
        bw_if.ShiftAmt = amt;
        bw_if.Flush    = fl;
        model_step(valid, data, sh, amt, fl);
        @(posedge clk);
        #1;
        bw_if.InValid = 1'b0;
        bw_if.Shift   = 1'b0;
        bw_if.Flush   = 1'b0;
    endtask

    task automatic test_reset();
        bw_if.InValid  = 1'b0;
        bw_if.InData   = '0;
        bw_if.Shift    = 1'b0;
        bw_if.ShiftAmt = '0;
        bw_if.Flush    = 1'b0;
        rst = 1'b1;
        model_q.delete();
        model_consumed  = 0;
        model_underflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bw_if.Window !== 32'h0) begin errors++; $display("FAIL reset_window got=%h exp=%h", bw_if.Window, 32'h0); end
        checks++; if (bw_if.WindowValid !== 1'b0) begin errors++; $display("FAIL reset_wvalid got=%b exp=0", bw_if.WindowValid); end
        checks++; if (bw_if.InReady !== 1'b0) begin errors++; $display("FAIL reset_inready got=%b exp=0", bw_if.InReady); end
        checks++; if (bw_if.BitsConsumed !== 32'd0) begin errors++; $display("FAIL reset_consumed got=%0d exp=0", bw_if.BitsConsumed); end
        checks++; if (bw_if.Underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got=%b exp=0", bw_if.Underflow); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bw_if.InReady !== 1'b1) begin errors++; $display("FAIL post_reset_inready got=%b exp=1", bw_if.InReady); end
        checks++; if (bw_if.WindowValid !== 1'b0) begin errors++; $display("FAIL post_reset_wvalid got=%b exp=0", bw_if.WindowValid); end
    endtask

    task automatic test_load();
        drive(1'b1, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
        checks++; if (bw_if.Window !== 32'hDEADBEEF) begin errors++; $display("FAIL load1_window got=%h exp=%h", bw_if.Window, 32'hDEADBEEF); end
        checks++; if (bw_if.InReady !== 1'b1) begin errors++; $display("FAIL load1_inready got=%b exp=1", bw_if.InReady); end
        drive(1'b1, 32'h01234567, 1'b0, 5'd0, 1'b0);
        checks++; if (bw_if.Window !== 32'hDEADBEEF) begin errors++; $display("FAIL load2_window got=%h exp=%h", bw_if.Window, 32'hDEADBEEF); end
        checks++; if (bw_if.WindowValid !== 1'b1) begin errors++; $display("FAIL load2_wvalid got=%b exp=1", bw_if.WindowValid); end
        checks++; if (bw_if.InReady !== 1'b0) begin errors++; $display("FAIL full_inready got=%b exp=0", bw_if.InReady); end
    endtask

    task automatic test_shift();
        drive(1'b0, 32'h0, 1'b1, 5'd16, 1'b0);
        checks++; if (bw_if.Window !== 32'hBEEF0123) begin errors++; $display("FAIL shift16_window got=%h exp=%h", bw_if.Window, 32'hBEEF0123); end
        checks++; if (bw_if.BitsConsumed !== 32'd16) begin errors++; $display("FAIL shift16_consumed got=%0d exp=16", bw_if.BitsConsumed); end
        checks++; if (bw_if.InReady !== 1'b0) begin errors++; $display("FAIL fill48_inready got=%b exp=0", bw_if.InReady); end
    endtask

    task automatic test_load_and_shift();
        drive(1'b0, 32'h0, 1'b1, 5'd16, 1'b0);
        checks++; if (bw_if.Window !== 32'h01234567) begin errors++; $display("FAIL fill32_window got=%h exp=%h", bw_if.Window, 32'h01234567); end
        checks++; if (bw_if.InReady !== 1'b1) begin errors++; $display("FAIL fill32_inready got=%b exp=1", bw_if.InReady); end
        drive(1'b1, 32'hFFFFFFFF, 1'b1, 5'd8, 1'b0);
        checks++; if (bw_if.Window !== 32'h234567FF) begin errors++; $display("FAIL simul_window got=%h exp=%h", bw_if.Window, 32'h234567FF); end
        checks++; if (bw_if.InReady !== 1'b0) begin errors++; $display("FAIL fill56_inready got=%b exp=0", bw_if.InReady); end
        drive(1'b0, 32'h0, 1'b1, 5'd24, 1'b0);
        checks++; if (bw_if.Window !== 32'hFFFFFFFF) begin errors++; $display("FAIL contiguous_window got=%h exp=%h", bw_if.Window, 32'hFFFFFFFF); end
        checks++; if (bw_if.BitsConsumed !== 32'd64) begin errors++; $display("FAIL simul_consumed got=%0d exp=64", bw_if.BitsConsumed); end
    endtask

    task automatic test_underflow();
        drive(1'b0, 32'h0, 1'b1, 5'd12, 1'b0);
        checks++; if (bw_if.Window !== 32'hFFFFF000) begin errors++; $display("FAIL fill20_window got=%h exp=%h", bw_if.Window, 32'hFFFFF000); end
        checks++; if (bw_if.WindowValid !== 1'b0) begin errors++; $display("FAIL fill20_wvalid got=%b exp=0", bw_if.WindowValid); end
        drive(1'b0, 32'h0, 1'b1, 5'd4, 1'b0);
        checks++; if (bw_if.Window !== 32'hFFFFF000) begin errors++; $display("FAIL ignored_shift_window got=%h exp=%h", bw_if.Window, 32'hFFFFF000); end
        checks++; if (bw_if.BitsConsumed !== 32'd76) begin errors++; $display("FAIL ignored_shift_consumed got=%0d exp=76", bw_if.BitsConsumed); end
        checks++; if (bw_if.Underflow !== 1'b1) begin errors++; $display("FAIL underflow_set got=%b exp=1", bw_if.Underflow); end
        drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
        checks++; if (bw_if.Underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky got=%b exp=1", bw_if.Underflow); end
    endtask

    task automatic test_flush();
        drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b1);
        checks++; if (bw_if.Underflow !== 1'b0) begin errors++; $display("FAIL flush_underflow got=%b exp=0", bw_if.Underflow); end
        checks++; if (bw_if.Window !== 32'h0) begin errors++; $display("FAIL flush_window got=%h exp=0", bw_if.Window); end
        drive(1'b1, 32'hAAAA5555, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 32'h12345678, 1'b0, 5'd0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 5'd16, 1'b0);
        checks++; if (bw_if.Window !== 32'h55551234) begin errors++; $display("FAIL fill48_window got=%h exp=%h", bw_if.Window, 32'h55551234); end
        drive(1'b1, 32'hCAFEF00D, 1'b1, 5'd8, 1'b1);
        checks++; if (bw_if.WindowValid !== 1'b0) begin errors++; $display("FAIL flush48_wvalid got=%b exp=0", bw_if.WindowValid); end
        checks++; if (bw_if.Window !== 32'h0) begin errors++; $display("FAIL flush48_window got=%h exp=0", bw_if.Window); end
        checks++; if (bw_if.BitsConsumed !== 32'd92) begin errors++; $display("FAIL flush_consumed_held got=%0d exp=92", bw_if.BitsConsumed); end
        // Empty buffer: InReady is high during the flush but the word must still be dropped.
        drive(1'b1, 32'hCAFEF00D, 1'b0, 5'd0, 1'b1);
        checks++; if (bw_if.Window !== 32'h0) begin errors++; $display("FAIL flush_void_load got=%h exp=0", bw_if.Window); end
        drive(1'b1, 32'h0F0F0F0F, 1'b0, 5'd0, 1'b0);
        checks++; if (bw_if.Window !== 32'h0F0F0F0F) begin errors++; $display("FAIL post_flush_load got=%h exp=%h", bw_if.Window, 32'h0F0F0F0F); end
    endtask

    task automatic test_random_stream();
        logic [31:0] words[1000];
        bit          dut_bits[$];
        int          idx;
        int          cycles;
        int          bad_bits;
        int unsigned base_consumed;
        logic        valid;
        logic [31:0] data;
        logic        sh;
        logic [4:0]  amt;

        drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b1);
        foreach (words[i]) words[i] = $urandom;
        base_consumed = model_consumed;
        idx    = 0;
        cycles = 0;
        while (!(idx == 1000 && model_q.size() < 32) && cycles < 20000) begin
            @(negedge clk);
            valid = (idx < 1000) && ($urandom_range(3) != 0);
            data  = valid ? words[idx] : $urandom;
            sh    = (model_q.size() >= 32) && ($urandom_range(4) != 0);
            amt   = 5'($urandom_range(16, 1));
            bw_if.InValid  = valid;
            bw_if.InData   = data;
            bw_if.Shift    = sh;
            bw_if.ShiftAmt = amt;
            bw_if.Flush    = 1'b0;
            #1;
            checks++; if (bw_if.Window !== model_window()) begin errors++; $display("FAIL rand_window cyc=%0d got=%h exp=%h", cycles, bw_if.Window, model_window()); end
            checks++; if (bw_if.WindowValid !== (model_q.size() >= 32)) begin errors++; $display("FAIL rand_wvalid cyc=%0d got=%b exp=%b", cycles, bw_if.WindowValid, model_q.size() >= 32); end
            checks++; if (bw_if.InReady !== (model_q.size() <= 32)) begin errors++; $display("FAIL rand_inready cyc=%0d got=%b exp=%b", cycles, bw_if.InReady, model_q.size() <= 32); end
            if (sh) begin
                for (int i = 0; i < int'(amt); i++) dut_bits.push_back(bw_if.Window[31-i]);
            end
            if (valid && model_q.size() <= 32) idx++;
            model_step(valid, data, sh, amt, 1'b0);
            @(posedge clk);
            cycles++;
        end
        #1;
        bw_if.InValid = 1'b0;
        bw_if.Shift   = 1'b0;
        checks++; if (cycles >= 20000) begin errors++; $display("FAIL rand_timeout got=%0d words exp=1000", idx); end
        bad_bits = 0;
        for (int k = 0; k < dut_bits.size(); k++) begin
            if (dut_bits[k] !== words[k/32][31 - (k % 32)]) bad_bits++;
        end
        checks++; if (bad_bits != 0) begin errors++; $display("FAIL rand_stream_bits got=%0d wrong bits exp=0", bad_bits); end
        checks++; if (dut_bits.size() != int'(model_consumed - base_consumed) || dut_bits.size() < 31000) begin
            errors++; $display("FAIL rand_stream_len got=%0d exp=%0d", dut_bits.size(), model_consumed - base_consumed); end
        checks++; if (bw_if.BitsConsumed !== 32'(model_consumed)) begin errors++; $display("FAIL rand_consumed got=%0d exp=%0d", bw_if.BitsConsumed, model_consumed); end
        checks++; if (bw_if.Underflow !== 1'b0) begin errors++; $display("FAIL rand_underflow got=%b exp=0", bw_if.Underflow); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shift();
        test_load_and_shift();
        test_underflow();
        test_flush();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
